// File: rtl/lstm_feeder_pkg.sv
// lstm_feeder_pkg: shared types and defaults for the LSTM syscall feeder
package lstm_feeder_pkg;
    localparam int X_SIZE_DEF = 8;
    localparam int H_SIZE_DEF = 8;
    typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT_DONE, CAPTURE} feeder_state_t;
    typedef enum logic [2:0] {
        SYSCALL_W       = 3'd0,
        SYSCALL_B       = 3'd1,
        SYSCALL_CONTEXT = 3'd2,
        IDLE_TYPE       = 3'd7
    } init_type_t;
endpackage

// File: rtl/feeder_vec_buf.sv
// feeder_vec_buf: 2-entry ping-pong vector buffer with commit/pop and occupancy count
module feeder_vec_buf import lstm_feeder_pkg::*; #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         commit,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wr, rd;
    assign rdata = mem[rd];
    // write on commit, advance read on pop; simultaneous commit+pop keeps the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (commit) begin
                mem[wr] <= wdata;
                wr      <= ~wr;
            end
            if (pop) rd <= ~rd;
            count <= count + {1'b0, commit} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/lstm_syscall_feeder.sv
// lstm_syscall_feeder: packs feature bytes into X vectors and paces them into the LSTM core
module lstm_syscall_feeder import lstm_feeder_pkg::*; #(
    parameter int X_SIZE       = X_SIZE_DEF,
    parameter int H_SIZE       = H_SIZE_DEF,
    parameter int GUARD_CYCLES = 2,
    parameter int SEQ_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                iByte_valid,
    input  logic [7:0]          iByte_data,
    output logic                oByte_ready,
    input  logic                iFlush,
    output logic                oNext_valid,
    output logic [X_SIZE*8-1:0] oData,
    input  logic                iLstm_done,
    input  logic [H_SIZE*8-1:0] iSys_Ht,
    output logic                oResult_valid,
    output logic [H_SIZE*8-1:0] oResult,
    output logic [SEQ_W-1:0]    oResult_seq,
    output logic                oBusy
);
    localparam int XW = X_SIZE * 8;
    localparam int CW = $clog2(X_SIZE) + 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1) + 1;

    logic [CW-1:0]    byte_cnt;
    logic [XW-1:0]    fill, packed_vec, head;
    logic [1:0]       count;
    logic             last_byte, accept, commit, pop;
    feeder_state_t    state, next_state;
    logic [GW-1:0]    guard;
    logic [SEQ_W-1:0] seq;

    assign last_byte   = byte_cnt == CW'(X_SIZE - 1);
    assign oByte_ready = !(count == 2'd2 && last_byte);
    assign accept      = iByte_valid & oByte_ready & ~iFlush;
    assign commit      = accept & last_byte;
    assign packed_vec  = {fill[XW-9:0], iByte_data};
    assign pop         = state == ISSUE;

    feeder_vec_buf #(.W(XW)) u_buf (
        .clk    (clk),
        .reset  (reset),
        .commit (commit),
        .wdata  (packed_vec),
        .pop    (pop),
        .rdata  (head),
        .count  (count)
    );

    // byte packing: shift left by a byte, commit on the last one, flush drops the partial vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            fill     <= '0;
        end else if (iFlush) begin
            byte_cnt <= '0;
            fill     <= '0;
        end else if (accept) begin
            byte_cnt <= commit ? '0 : byte_cnt + CW'(1);
            fill     <= commit ? '0 : packed_vec;
        end
    end

    // state register plus issue data, guard counter and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            guard       <= '0;
            seq         <= '0;
            oData       <= '0;
            oResult     <= '0;
            oResult_seq <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == ISSUE) oData <= head;
            if (state == ISSUE) guard <= GW'(GUARD_CYCLES - 1);
            else if (state == GUARD) guard <= guard - GW'(1);
            if (state == WAIT_DONE && iLstm_done) begin
                oResult     <= iSys_Ht;
                oResult_seq <= seq;
                seq         <= seq + SEQ_W'(1);
            end
        end
    end

    // next-state and strobes; done is only looked at in IDLE and WAIT_DONE
    always_comb begin
        next_state    = state;
        oNext_valid   = 1'b0;
        oResult_valid = 1'b0;
        oBusy         = state != IDLE;
        case (state)
            IDLE:      if (count != 2'd0 && iLstm_done) next_state = ISSUE;
            ISSUE: begin
                oNext_valid = 1'b1;
                next_state  = (GUARD_CYCLES > 1) ? GUARD : WAIT_DONE;
            end
            GUARD:     if (guard == GW'(1)) next_state = WAIT_DONE;
            WAIT_DONE: if (iLstm_done) next_state = CAPTURE;
            CAPTURE: begin
                oResult_valid = 1'b1;
                next_state    = IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lstm_syscall_feeder.sv
// tb_lstm_syscall_feeder: table-driven scoreboard bench for the syscall feeder
module tb_lstm_syscall_feeder;
    localparam int G = 2;

    typedef struct {
        logic [63:0] v;
        logic [63:0] ht;
    } vec_t;
    typedef struct {
        logic [63:0] h;
        logic [15:0] s;
    } res_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        iByte_valid = 1'b0, iFlush = 1'b0;
    logic [7:0]  iByte_data = '0;
    logic        oByte_ready, oNext_valid, oResult_valid, oBusy, iLstm_done;
    logic [63:0] oData, oResult, iSys_Ht = '0;
    logic [15:0] oResult_seq;
    logic        done_m = 1'b1, core_hold = 1'b0;
    int          core_lat = 2;

    vec_t        tbl [5];
    logic [63:0] exp_data [$];
    logic [63:0] core_ht [$];
    res_t        exp_res [$];
    int          iss_q [$];
    logic [15:0] exp_seq = '0;
    int          n_chk = 0, n_pass = 0, cyc = 0;
    int          issue_cyc = 0, acc_cyc = 0, n_issue = 0, n_res = 0, n0 = 0;

    assign iLstm_done = done_m & ~core_hold;

    lstm_syscall_feeder #(.X_SIZE(8), .H_SIZE(8), .GUARD_CYCLES(G), .SEQ_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .iByte_valid   (iByte_valid),
        .iByte_data    (iByte_data),
        .oByte_ready   (oByte_ready),
        .iFlush        (iFlush),
        .oNext_valid   (oNext_valid),
        .oData         (oData),
        .iLstm_done    (iLstm_done),
        .iSys_Ht       (iSys_Ht),
        .oResult_valid (oResult_valid),
        .oResult       (oResult),
        .oResult_seq   (oResult_seq),
        .oBusy         (oBusy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, got, want);
    endtask

    task automatic fail_timeout(input string nm);
        n_chk++;
        $display("FAIL %s: got timeout, want event", nm);
    endtask

    task automatic monitor();
        res_t r;
        forever begin
            @(negedge clk);
            if (oNext_valid) begin
                issue_cyc = cyc;
                iss_q.push_back(cyc);
                n_issue++;
                if (exp_data.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_issue: got oData=%h, want no issue", oData);
                end else chk("oData", oData, exp_data.pop_front());
            end
            if (oResult_valid) begin
                n_res++;
                if (exp_res.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_result: got oResult=%h, want no result", oResult);
                end else begin
                    r = exp_res.pop_front();
                    chk("oResult", oResult, r.h);
                    chk("oResult_seq", 64'(oResult_seq), 64'(r.s));
                    if (core_lat == 0) chk("guard_lat", 64'(cyc - issue_cyc), 64'(G + 1));
                end
            end
        end
    endtask

    task automatic core_model();
        int busy = 0;
        logic [63:0] cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy   = 0;
                done_m = 1'b1;
            end else if (oNext_valid) begin
                cur = (core_ht.size() != 0) ? core_ht.pop_front() : '0;
                if (core_lat == 0) begin
                    iSys_Ht = cur;
                    done_m  = 1'b1;
                end else begin
                    done_m = 1'b0;
                    busy   = core_lat;
                end
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    iSys_Ht = cur;
                    done_m  = 1'b1;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        iByte_valid = 1'b1;
        iByte_data  = b;
        while (!oByte_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_timeout("byte_ready");
        @(negedge clk);
        iByte_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send_vec(input logic [63:0] v, input logic [63:0] ht, input int nb);
        exp_data.push_back(v);
        core_ht.push_back(ht);
        exp_res.push_back('{h: ht, s: exp_seq});
        exp_seq++;
        for (int i = 0; i < nb; i++) send_byte(v[63-8*i -: 8]);
    endtask

    task automatic wait_issue(input int base);
        int t = 0;
        while (n_issue == base && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_timeout("wait_issue");
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_res.size() != 0 || exp_data.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail_timeout("drain");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{v: 64'h0102030405060708, ht: {8{8'hAA}}};
        tbl[1] = '{v: 64'h1122334455667788, ht: {8{8'hBB}}};
        tbl[2] = '{v: 64'hF0E1D2C3B4A59687, ht: {8{8'hCC}}};
        tbl[3] = '{v: 64'h00FF00FF5A5AA5A5, ht: 64'h0123456789ABCDEF};
        tbl[4] = '{v: {$urandom, $urandom}, ht: {$urandom, $urandom}};
        fork
            monitor();
            core_model();
        join_none
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(oByte_ready), 64'd1);
        chk("rst_next_valid", 64'(oNext_valid), 64'd0);
        chk("rst_data", oData, 64'd0);
        chk("rst_result_valid", 64'(oResult_valid), 64'd0);
        chk("rst_result", oResult, 64'd0);
        chk("rst_seq", 64'(oResult_seq), 64'd0);
        chk("rst_busy", 64'(oBusy), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // table pass: pack order, issue latency and in-order results
        core_lat = 2;
        for (int i = 0; i < 5; i++) begin
            n0 = n_issue;
            send_vec(tbl[i].v, tbl[i].ht, 8);
            if (i == 0) begin
                wait_issue(n0);
                chk("issue_lat", 64'(issue_cyc - acc_cyc), 64'd1);
                @(negedge clk);
                chk("strobe_width", 64'(oNext_valid), 64'd0);
            end
        end
        drain();
        chk("result_count", 64'(n_res), 64'd5);

        // backpressure with the core held busy, then back-to-back issue spacing
        core_hold = 1'b1;
        core_lat  = 0;
        n0 = n_issue;
        send_vec(tbl[1].v, tbl[1].ht, 8);
        send_vec(tbl[2].v, tbl[2].ht, 8);
        send_vec(tbl[3].v, tbl[3].ht, 7);
        chk("ready_full", 64'(oByte_ready), 64'd0);
        iByte_valid = 1'b1;
        iByte_data  = tbl[3].v[7:0];
        repeat (3) @(negedge clk);
        chk("ready_held", 64'(oByte_ready), 64'd0);
        chk("no_issue_held", 64'(n_issue - n0), 64'd0);
        iss_q.delete();
        core_hold = 1'b0;
        send_byte(tbl[3].v[7:0]);
        drain();
        chk("issue_count", 64'(iss_q.size()), 64'd3);
        if (iss_q.size() >= 3) begin
            chk("spacing_1", 64'(iss_q[1] - iss_q[0]), 64'(G + 3));
            chk("spacing_2", 64'(iss_q[2] - iss_q[1]), 64'(G + 3));
        end

        // flush wins over a same-cycle byte; only the fresh vector is issued
        core_lat = 2;
        n0 = n_issue;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i));
        iFlush      = 1'b1;
        iByte_valid = 1'b1;
        iByte_data  = 8'hEE;
        @(negedge clk);
        iFlush      = 1'b0;
        iByte_valid = 1'b0;
        send_vec(tbl[4].v, tbl[4].ht, 8);
        drain();
        chk("flush_issues", 64'(n_issue - n0), 64'd1);

        // reset while waiting on the core aborts the issued vector
        core_lat = 20;
        n0 = n_issue;
        exp_data.push_back(tbl[0].v);
        core_ht.push_back(tbl[0].ht);
        for (int i = 0; i < 8; i++) send_byte(tbl[0].v[63-8*i -: 8]);
        wait_issue(n0);
        repeat (3) @(negedge clk);
        chk("busy_wait", 64'(oBusy), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(oByte_ready), 64'd1);
        chk("mid_rst_next_valid", 64'(oNext_valid), 64'd0);
        chk("mid_rst_data", oData, 64'd0);
        chk("mid_rst_result_valid", 64'(oResult_valid), 64'd0);
        chk("mid_rst_result", oResult, 64'd0);
        chk("mid_rst_seq", 64'(oResult_seq), 64'd0);
        chk("mid_rst_busy", 64'(oBusy), 64'd0);
        exp_data.delete();
        core_ht.delete();
        exp_res.delete();
        exp_seq = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n0 = n_issue;
        repeat (5) @(negedge clk);
        chk("no_issue_after_rst", 64'(n_issue - n0), 64'd0);
        core_lat = 2;
        send_vec(tbl[1].v, tbl[1].ht, 8);
        drain();
        chk("post_rst_issues", 64'(n_issue - n0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
